// File: rtl/decoder2to4_seq_if.sv
// Handshake and output bundle for decoder2to4_seq.
// The master side drives the code, enable, valid and sweep request; the slave side returns ready and the decoded lines.
interface decoder2to4_seq_if;
  logic [1:0] A;
  logic       E;
  logic       valid_in;
  logic       ready_out;
  logic       sweep;
  logic [3:0] D;
  logic       D_valid;
  logic       busy;

  modport master (
    output A, E, valid_in, sweep,
    input  ready_out, D, D_valid, busy
  );

  modport slave (
    input  A, E, valid_in, sweep,
    output ready_out, D, D_valid, busy
  );
endinterface

// File: rtl/decoder2to4_seq.sv
// Registered, handshaked 2-to-4 decoder: each accepted code drives one line for HOLD_CYCLES, then one all-zero gap.
// Optional self-test sweep of codes 0..3 is built only when DECODER_SWEEP_EN is defined.
module decoder2to4_seq #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  decoder2to4_seq_if.slave   bus
);

  // A hold of 0 is treated as 1; the counter counts the extra cycles beyond the first.
  localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES <= 1) ? 8'd0 : 8'(HOLD_CYCLES - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_HOLD       = 3'd1;
  localparam logic [2:0] S_GAP        = 3'd2;
`ifdef DECODER_SWEEP_EN
  localparam logic [2:0] S_SWEEP_HOLD = 3'd3;
  localparam logic [2:0] S_SWEEP_GAP  = 3'd4;
`endif

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] d_q, d_d;
  logic       dv_q, dv_d;
  logic       busy_q, busy_d;

`ifdef DECODER_SWEEP_EN
  logic [1:0] idx_q, idx_d;
`else
  logic       unused_sweep;
  assign unused_sweep = bus.sweep;
`endif

  function automatic logic [3:0] onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  assign bus.ready_out = (state_q == S_IDLE) && !rst;
  assign bus.D         = d_q;
  assign bus.D_valid   = dv_q;
  assign bus.busy      = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    dv_d    = dv_q;
`ifdef DECODER_SWEEP_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A code offered in the same cycle as a sweep request wins.
        if (bus.valid_in) begin
          if (bus.E) begin
            state_d = S_HOLD;
            d_d     = onehot(bus.A);
            dv_d    = 1'b1;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = S_GAP;
          end
        end
`ifdef DECODER_SWEEP_EN
        else if (bus.sweep) begin
          state_d = S_SWEEP_HOLD;
          d_d     = onehot(idx_q);
          dv_d    = 1'b1;
          cnt_d   = HOLD_LOAD;
        end
`endif
      end
      S_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_GAP;
          d_d     = 4'b0000;
          dv_d    = 1'b0;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
`ifdef DECODER_SWEEP_EN
      S_SWEEP_HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_SWEEP_GAP;
          d_d     = 4'b0000;
          dv_d    = 1'b0;
        end
      end
      S_SWEEP_GAP: begin
        // Index wraps to 0 after code 3 so the next sweep starts from the bottom.
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SWEEP_HOLD;
          d_d     = onehot(idx_q + 2'd1);
          dv_d    = 1'b1;
          cnt_d   = HOLD_LOAD;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        d_d     = 4'b0000;
        dv_d    = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      d_q     <= 4'b0000;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef DECODER_SWEEP_EN
      idx_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
`ifdef DECODER_SWEEP_EN
      idx_q   <= idx_d;
`endif
    end
  end

endmodule
